// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with frame-aligned double-buffered digit codes.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module seven_seg_scan_ctrl #(
    parameter int NDIG  = 8,
    parameter int DIV   = 100000,
    parameter int GUARD = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [7*NDIG-1:0] i_digits_in,
    output logic              o_pending,
    output logic [6:0]        o_d,
    output logic [NDIG-1:0]   o_an_n,
    output logic              o_frame_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD);
    localparam logic [IW-1:0] IDX_MAX   = IW'(NDIG - 1);
    localparam logic [6:0]    CODE_BLANK = 7'h40;

    if (NDIG < 1 || NDIG > 8) begin : g_bad_ndig
        $fatal(1, "seven_seg_scan_ctrl: NDIG must be in 1..8");
    end
    if (DIV <= GUARD) begin : g_bad_div
        $fatal(1, "seven_seg_scan_ctrl: DIV must be greater than GUARD");
    end
    if (GUARD < 1) begin : g_bad_guard
        $fatal(1, "seven_seg_scan_ctrl: GUARD must be at least 1");
    end

    typedef enum logic {StBlank, StDrive} state_t;

    logic [CW-1:0]     r_cnt, w_cnt_d;
    logic [IW-1:0]     r_idx, w_idx_d;
    state_t            r_state, w_state_d;
    logic [7*NDIG-1:0] r_active, w_active_d;
    logic [7*NDIG-1:0] r_shadow, w_shadow_d;
    logic              r_pending, w_pending_d;
    logic [6:0]        r_d, w_d_d;
    logic [NDIG-1:0]   r_an_n, w_an_n_d;
    logic              r_frame_tick, w_frame_tick_d;
    logic              w_wrap, w_boundary;
    logic [NDIG-1:0]   w_blank_mask;
    logic [6:0]        w_code;

    assign w_wrap     = (r_cnt == CNT_MAX);
    assign w_boundary = (r_cnt == '0) && (r_idx == '0);

    always_comb begin
        w_cnt_d = w_wrap ? '0 : r_cnt + 1'b1;
        w_idx_d = r_idx;
        if (w_wrap) begin
            w_idx_d = (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
        end
    end

    // A load landing on the boundary bypasses the shadow and drops whatever it held.
    always_comb begin
        w_active_d  = r_active;
        w_shadow_d  = r_shadow;
        w_pending_d = r_pending;
        if (w_boundary) begin
            if (i_load) begin
                w_active_d = i_digits_in;
            end else if (r_pending) begin
                w_active_d = r_shadow;
            end
            w_pending_d = 1'b0;
        end else if (i_load) begin
            w_shadow_d  = i_digits_in;
            w_pending_d = 1'b1;
        end
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StBlank: if (w_cnt_d == CNT_GUARD) w_state_d = StDrive;
            StDrive: if (w_wrap) w_state_d = StBlank;
            default: w_state_d = StBlank;
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        logic w_lead;
        w_lead       = 1'b1;
        w_blank_mask = '0;
        for (int i = NDIG - 1; i >= 1; i--) begin
            if (w_lead && (w_active_d[7*i +: 7] == 7'h00)) begin
                w_blank_mask[i] = 1'b1;
            end else begin
                w_lead = 1'b0;
            end
        end
    end
`else
    assign w_blank_mask = '0;
`endif

    // Outputs are registered from next-state values so they match (cnt, idx) of their own cycle.
    always_comb begin
        w_code = CODE_BLANK;
        for (int i = 0; i < NDIG; i++) begin
            if (w_idx_d == IW'(i)) begin
                w_code = w_blank_mask[i] ? CODE_BLANK : w_active_d[7*i +: 7];
            end
        end
    end

    always_comb begin
        w_an_n_d       = '1;
        w_d_d          = CODE_BLANK;
        w_frame_tick_d = (w_cnt_d == '0) && (w_idx_d == '0);
        if (w_state_d == StDrive) begin
            w_d_d = w_code;
            for (int i = 0; i < NDIG; i++) begin
                if (w_idx_d == IW'(i)) begin
                    w_an_n_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_state      <= StBlank;
            r_active     <= {NDIG{CODE_BLANK}};
            r_shadow     <= {NDIG{CODE_BLANK}};
            r_pending    <= 1'b0;
            r_d          <= CODE_BLANK;
            r_an_n       <= '1;
            r_frame_tick <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_d;
            r_idx        <= w_idx_d;
            r_state      <= w_state_d;
            r_active     <= w_active_d;
            r_shadow     <= w_shadow_d;
            r_pending    <= w_pending_d;
            r_d          <= w_d_d;
            r_an_n       <= w_an_n_d;
            r_frame_tick <= w_frame_tick_d;
        end
    end

    assign o_pending    = r_pending;
    assign o_d          = r_d;
    assign o_an_n       = r_an_n;
    assign o_frame_tick = r_frame_tick;

endmodule
